fp2int_conv: RTL and testbench
==============================

Name: fp2int_conv

Overview:
- Multi-cycle converter from an IEEE-754 single-precision operand to a signed 32-bit two's-complement integer, rounding toward zero (C-cast semantics).
- Consumes packed floats such as those produced by the team's FP adder.
- Uses the same start/done handshake style, with a one-bit-per-cycle serial shifter.
- Sits downstream of FP arithmetic, in front of integer datapaths and register writeback.

Parameters:
- None. Fixed at single-precision input and 32-bit signed output.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous reset, active-low (asserted when 0, sampled on rising clk)
- start  input  1  one-cycle request; sampled only in IDLE
- a  input  32  float operand {sign, exp[7:0], frac[22:0]}; sampled on the start edge only
- result  output  32  signed integer result; holds its value until the next completion or reset
- done  output  1  completion pulse; high for exactly one cycle per accepted start
- busy  output  1  high from the edge that accepts start until the edge that raises done
- invalid  output  1  NaN, Inf or out-of-range input; valid while done=1, then held
- inexact  output  1  nonzero fraction bits were discarded; valid while done=1, then held

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE; result=0, done=0, busy=0, invalid=0, inexact=0.
  - Overrides start and aborts any conversion in flight. No done is produced for the aborted job.
- States: IDLE, CLASSIFY, SHIFT, SIGN, FINISH.
- IDLE:
  - start=1 latches sgn, exp, mant={1,frac}; busy<=1; done<=0; next state CLASSIFY.
  - start=0: stay in IDLE; done<=0.
- CLASSIFY (one edge):
  - exp==255 (NaN or Inf): value=0x7FFFFFFF for NaN or +Inf, 0x80000000 for -Inf; invalid=1, inexact=0; go to FINISH.
  - exp>=158:
    - Negative with exp==158 and frac==0: value=0x80000000, invalid=0, inexact=0.
    - Otherwise saturate: 0x7FFFFFFF if sgn=0, 0x80000000 if sgn=1; invalid=1.
    - Go to FINISH.
  - exp<=126, including zero and denormals:
    - value=0, invalid=0.
    - inexact=1 unless exp==0 and frac==0.
    - Go to FINISH.
  - Otherwise (127..157):
    - Load shift register sr[31:0]={8'b0,mant}; clear the sticky bit.
    - exp>=150: direction=left, count=exp-150 (0..7).
    - exp<150: direction=right, count=150-exp (1..23).
    - count==0: go to SIGN; otherwise go to SHIFT.
- SHIFT:
  - One bit per edge. Right shift ORs the outgoing bit sr[0] into sticky; left shift fills with 0.
  - count decrements each edge; the edge on which count reaches 0 moves to SIGN.
- SIGN (one edge):
  - value = sgn ? (~sr+1) : sr, computed in 32 bits.
  - inexact=sticky; invalid=0.
  - Go to FINISH.
- FINISH (one edge):
  - result<=value, invalid and inexact flags registered.
  - done<=1, busy<=0; go to IDLE.
- On the edge after FINISH, IDLE clears done. result and the flags hold.
- Latency, counted in edges from the start edge to the edge that raises done:
  - Special or early-exit cases: 2.
  - Normal cases: count+3 (worst case 26 for exp=127).
- start while busy=1 is ignored: no queuing and no effect on the current job.
- start asserted in the same cycle that done is high (state IDLE) is accepted, giving back-to-back operation.
- a may change freely after the start edge.
- Magnitude never exceeds 0x7FFFFF80 on the normal path, so negation never overflows.

Test Plan:
- reset=0 for 2 cycles, then release -> result=0, done=0, busy=0, invalid=0, inexact=0.
- a=0x3F800000 (1.0), start pulse -> done on the 26th edge after start, result=0x00000001, invalid=0, inexact=0. busy stays high throughout and start pulses mid-job are ignored.
- a=0xC0200000 (-2.5) -> result=0xFFFFFFFE, inexact=1, invalid=0.
- a=0x4EFFFFFF -> result=0x7FFFFF80, latency 10 edges.
- a=0x4F000000 -> result=0x7FFFFFFF, invalid=1, latency 2 edges.
- a=0xCF000000 -> result=0x80000000, invalid=0.
- a=0x7FC00000 (NaN) -> result=0x7FFFFFFF, invalid=1.
- a=0x3F000000 (0.5) -> result=0, inexact=1.
- a=0x80000000 (-0) -> result=0, inexact=0.
- Start 0x3F800000, pull reset low at edge 10 -> no done, all outputs 0. Then start 0x42F60000 (123.0) -> result=0x0000007B.
- Back-to-back: assert start while done=1 with a=0x40400000 (3.0) -> accepted, result=0x00000003 after 25 edges.

Source files
------------

// File: rtl/fp2int_conv_if.sv
// Start/done handshake bundle for the float-to-int converter.
// The requester drives start and a; the converter returns result and status flags.
interface fp2int_conv_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        invalid;
  logic        inexact;

  modport master (output start, a, input result, done, busy, invalid, inexact);
  modport slave  (input start, a, output result, done, busy, invalid, inexact);
endinterface

// File: rtl/fp2int_conv.sv
// Multi-cycle IEEE-754 single to int32 converter, round toward zero.
// The mantissa is aligned one bit per cycle through a serial shifter.
module fp2int_conv (
  input  logic          clk,
  input  logic          reset,
  fp2int_conv_if.slave  bus
);

  localparam int unsigned W      = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [2:0] {S_IDLE, S_CLASSIFY, S_SHIFT, S_SIGN, S_FINISH} state_t;

  state_t              state_q, state_d;
  logic                sgn_q, sgn_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic [MANT_W-1:0]   mant_q, mant_d;
  logic [W-1:0]        sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                left_q, left_d;
  logic                sticky_q, sticky_d;
  logic [W-1:0]        value_q, value_d;
  logic                inv_q, inv_d;
  logic                inx_q, inx_d;
  logic [W-1:0]        result_q, result_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                invalid_q, invalid_d;
  logic                inexact_q, inexact_d;
  logic [EXP_W-1:0]    shamt_c;
  logic                frac_zero_c;

  // Distance of the exponent from 150, where the integer point sits just below mant[0].
  assign shamt_c     = (exp_q >= 8'd150) ? (exp_q - 8'd150) : (8'd150 - exp_q);
  assign frac_zero_c = (mant_q[MANT_W-2:0] == '0);

  always_comb begin
    state_d   = state_q;
    sgn_d     = sgn_q;
    exp_d     = exp_q;
    mant_d    = mant_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    sticky_d  = sticky_q;
    value_d   = value_q;
    inv_d     = inv_q;
    inx_d     = inx_q;
    result_d  = result_q;
    done_d    = done_q;
    busy_d    = busy_q;
    invalid_d = invalid_q;
    inexact_d = inexact_q;

    unique case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (bus.start) begin
          sgn_d   = bus.a[31];
          exp_d   = bus.a[30:23];
          mant_d  = {1'b1, bus.a[22:0]};
          busy_d  = 1'b1;
          state_d = S_CLASSIFY;
        end
      end

      S_CLASSIFY: begin
        state_d = S_FINISH;
        inv_d   = 1'b0;
        inx_d   = 1'b0;
        if (exp_q == 8'hFF) begin
          value_d = (sgn_q && frac_zero_c) ? 32'h8000_0000 : 32'h7FFF_FFFF;
          inv_d   = 1'b1;
        end else if (exp_q >= 8'd158) begin
          // -2^31 is the only representable value at or above this exponent.
          if (sgn_q && exp_q == 8'd158 && frac_zero_c) begin
            value_d = 32'h8000_0000;
          end else begin
            value_d = sgn_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
            inv_d   = 1'b1;
          end
        end else if (exp_q <= 8'd126) begin
          value_d = '0;
          inx_d   = !(exp_q == '0 && frac_zero_c);
        end else begin
          sr_d     = {8'b0, mant_q};
          sticky_d = 1'b0;
          left_d   = (exp_q >= 8'd150);
          cnt_d    = CNT_W'(shamt_c);
          state_d  = (shamt_c == '0) ? S_SIGN : S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (left_q) begin
          sr_d = {sr_q[W-2:0], 1'b0};
        end else begin
          sr_d     = {1'b0, sr_q[W-1:1]};
          sticky_d = sticky_q | sr_q[0];
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_SIGN;
        end
      end

      S_SIGN: begin
        value_d = sgn_q ? (~sr_q + 32'd1) : sr_q;
        inx_d   = sticky_q;
        inv_d   = 1'b0;
        state_d = S_FINISH;
      end

      S_FINISH: begin
        result_d  = value_q;
        invalid_d = inv_q;
        inexact_d = inx_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      sgn_q     <= 1'b0;
      exp_q     <= '0;
      mant_q    <= '0;
      sr_q      <= '0;
      cnt_q     <= '0;
      left_q    <= 1'b0;
      sticky_q  <= 1'b0;
      value_q   <= '0;
      inv_q     <= 1'b0;
      inx_q     <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      invalid_q <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sgn_q     <= sgn_d;
      exp_q     <= exp_d;
      mant_q    <= mant_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      sticky_q  <= sticky_d;
      value_q   <= value_d;
      inv_q     <= inv_d;
      inx_q     <= inx_d;
      result_q  <= result_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      invalid_q <= invalid_d;
      inexact_q <= inexact_d;
    end
  end

  assign bus.result  = result_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.invalid = invalid_q;
  assign bus.inexact = inexact_q;

endmodule

// File: tb/tb_fp2int_conv.sv
// Bench for fp2int_conv: directed vectors, reset abort, back-to-back and random
// operands checked against an arithmetic reference of C-cast conversion.
module tb_fp2int_conv;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  fp2int_conv_if ifc ();

  fp2int_conv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncating float->int32 with saturation, plus expected latency in edges.
  function automatic void ref_model(input logic [31:0] av, output logic [31:0] r,
                                    output bit inv, output bit inx, output int lat);
    int     e;
    bit     sg;
    longint mant, full, mag, sv;
    sg   = av[31];
    e    = int'(av[30:23]) - 127;
    mant = longint'({1'b1, av[22:0]});
    r = '0; inv = 1'b0; inx = 1'b0; lat = 2;
    if (av[30:23] == 8'hFF) begin
      inv = 1'b1;
      r   = (sg && av[22:0] == 23'd0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (e < 0) begin
      inx = (av[30:0] != 31'd0);
    end else if (e > 31) begin
      inv = 1'b1;
      r   = sg ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      full = mant << e;
      mag  = full >> 23;
      sv   = sg ? -mag : mag;
      if (sv > 64'sd2147483647 || sv < -64'sd2147483648) begin
        inv = 1'b1;
        r   = sg ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        r   = 32'(sv);
        inx = ((full & 64'h7F_FFFF) != 0);
        if (e < 31) lat = ((e > 23) ? e - 23 : 23 - e) + 3;
      end
    end
  endfunction

  // Issues one start and waits (bounded) for done; optionally pokes start mid-job.
  task automatic do_conv(input logic [31:0] av, input bit poke,
                         output logic [31:0] r, output bit inv, output bit inx,
                         output int lat, output bit busy_ok, output bit to);
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.a     = av;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    ifc.a     = $urandom;
    busy_ok = (ifc.busy === 1'b1) && (ifc.done === 1'b0);
    to = 1'b1; lat = 0; r = '0; inv = 1'b0; inx = 1'b0;
    for (int i = 1; i <= 40 && to; i++) begin
      if (poke && (i == 2 || i == 4)) begin
        ifc.start = 1'b1;
        ifc.a     = $urandom;
      end else begin
        ifc.start = 1'b0;
      end
      @(posedge clk); #1;
      if (ifc.done === 1'b1) begin
        to = 1'b0; lat = i;
        r = ifc.result; inv = ifc.invalid; inx = ifc.inexact;
        if (ifc.busy !== 1'b0) busy_ok = 1'b0;
      end else if (ifc.busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
    end
    ifc.start = 1'b0;
  endtask

  task automatic test_reset();
    ifc.start = 1'b0; ifc.a = '0; reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({ifc.result, ifc.done, ifc.busy, ifc.invalid, ifc.inexact} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_state: got result=%h done=%b busy=%b inv=%b inx=%b, want all 0",
               ifc.result, ifc.done, ifc.busy, ifc.invalid, ifc.inexact);
    end
  endtask

  task automatic test_directed();
    logic [31:0] dv [9] = '{32'h3F80_0000, 32'hC020_0000, 32'h4EFF_FFFF, 32'h4F00_0000,
                            32'hCF00_0000, 32'h7FC0_0000, 32'h3F00_0000, 32'h8000_0000,
                            32'hFF80_0000};
    logic [31:0] dr [9] = '{32'h0000_0001, 32'hFFFF_FFFE, 32'h7FFF_FF80, 32'h7FFF_FFFF,
                            32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000,
                            32'h8000_0000};
    logic [31:0] r, er;
    bit inv, inx, einv, einx, bok, to;
    int lat, elat;
    for (int k = 0; k < 9; k++) begin
      ref_model(dv[k], er, einv, einx, elat);
      do_conv(dv[k], elat >= 6, r, inv, inx, lat, bok, to);
      n_checks++;
      if (to) begin
        n_fail++; $display("FAIL dir_timeout a=%h: no done within 40 edges", dv[k]);
      end else begin
        if (r !== dr[k]) begin
          n_fail++; $display("FAIL dir_result a=%h: got %h want %h", dv[k], r, dr[k]);
        end
        n_checks++;
        if ({inv, inx} !== {einv, einx}) begin
          n_fail++; $display("FAIL dir_flags a=%h: got inv=%b inx=%b want inv=%b inx=%b",
                             dv[k], inv, inx, einv, einx);
        end
        n_checks++;
        if (lat !== elat) begin
          n_fail++; $display("FAIL dir_latency a=%h: got %0d want %0d", dv[k], lat, elat);
        end
        n_checks++;
        if (!bok) begin
          n_fail++; $display("FAIL dir_busy a=%h: busy/done not as required during job", dv[k]);
        end
        @(posedge clk); #1;
        n_checks++;
        if (ifc.done !== 1'b0 || ifc.result !== dr[k]) begin
          n_fail++; $display("FAIL dir_hold a=%h: got done=%b result=%h want done=0 result=%h",
                             dv[k], ifc.done, ifc.result, dr[k]);
        end
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] r;
    bit inv, inx, bok, to, seen;
    int lat;
    @(negedge clk);
    ifc.start = 1'b1; ifc.a = 32'h3F80_0000;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({ifc.result, ifc.done, ifc.busy, ifc.invalid, ifc.inexact} !== 36'd0) begin
      n_fail++;
      $display("FAIL abort_state: got result=%h done=%b busy=%b, want all 0",
               ifc.result, ifc.done, ifc.busy);
    end
    reset = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (ifc.done === 1'b1 || ifc.busy === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL abort_no_done: got done/busy after abort, want none");
    end
    do_conv(32'h42F6_0000, 1'b0, r, inv, inx, lat, bok, to);
    n_checks++;
    if (to || r !== 32'h0000_007B || inv !== 1'b0 || inx !== 1'b0) begin
      n_fail++; $display("FAIL abort_restart: got result=%h inv=%b inx=%b to=%b want 0000007b 0 0",
                         r, inv, inx, to);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    bit inv, inx, bok, to;
    int lat;
    do_conv(32'h3F80_0000, 1'b0, r, inv, inx, lat, bok, to);
    n_checks++;
    if (to || ifc.done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first: got done=%b to=%b want done=1", ifc.done, to);
    end
    ifc.start = 1'b1; ifc.a = 32'h4040_0000;
    @(posedge clk); #1;
    ifc.start = 1'b0; ifc.a = $urandom;
    n_checks++;
    if (ifc.busy !== 1'b1 || ifc.done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", ifc.busy, ifc.done);
    end
    to = 1'b1; lat = 0;
    for (int i = 1; i <= 40 && to; i++) begin
      @(posedge clk); #1;
      if (ifc.done === 1'b1) begin to = 1'b0; lat = i; end
    end
    n_checks++;
    if (to || lat != 25 || ifc.result !== 32'h0000_0003) begin
      n_fail++; $display("FAIL b2b_second: got lat=%0d result=%h to=%b want 25 00000003",
                         lat, ifc.result, to);
    end
  endtask

  task automatic test_random();
    logic [31:0] av, r, er;
    bit inv, inx, einv, einx, bok, to;
    int lat, elat;
    for (int k = 0; k < 200; k++) begin
      av = $urandom;
      if (k % 4 != 0) av[30:23] = 8'(119 + $urandom_range(0, 42));
      if (k % 16 == 5) av[22:0] = '0;
      ref_model(av, er, einv, einx, elat);
      do_conv(av, (k % 3 == 0) && elat >= 6, r, inv, inx, lat, bok, to);
      n_checks++;
      if (to || r !== er || inv !== einv || inx !== einx || lat != elat || !bok) begin
        n_fail++;
        $display("FAIL rand_conv a=%h: got r=%h inv=%b inx=%b lat=%0d busy_ok=%b to=%b want r=%h inv=%b inx=%b lat=%0d",
                 av, r, inv, inx, lat, bok, to, er, einv, einx, elat);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    ifc.start = 1'b0;
    ifc.a = '0;
    test_reset();
    test_directed();
    test_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
